// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes the operation, computes result, zero flag and branch target, and
// registers all three in one output stage. Define ALU_MUL_EN to add the R-type MUL (funct 011000).
module alu_exec_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [5:0]  funct_i,
    input  logic [1:0]  alu_op_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] imm_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic [31:0] target_o
);

    typedef enum logic [2:0] {
        AluAnd = 3'b000,
        AluOr  = 3'b001,
        AluAdd = 3'b010,
        AluMul = 3'b011,
        AluSub = 3'b110,
        AluSlt = 3'b111
    } alu_ctrl_e;

    alu_ctrl_e   alu_ctrl;
    logic [31:0] alu_res;
    logic [31:0] target;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic [31:0] target_d, target_q;

    always_comb begin
        alu_ctrl = AluAdd;
        unique case (alu_op_i)
            2'b00: alu_ctrl = AluAdd;
            2'b01: alu_ctrl = AluSub;
            2'b11: alu_ctrl = AluOr;
            2'b10: begin
                case (funct_i)
                    6'b100000: alu_ctrl = AluAdd;
                    6'b100010: alu_ctrl = AluSub;
                    6'b100100: alu_ctrl = AluAnd;
                    6'b100101: alu_ctrl = AluOr;
                    6'b101010: alu_ctrl = AluSlt;
`ifdef ALU_MUL_EN
                    6'b011000: alu_ctrl = AluMul;
`endif
                    default:   alu_ctrl = AluAdd;
                endcase
            end
            default: alu_ctrl = AluAdd;
        endcase
    end

    always_comb begin
        alu_res = data1_i + data2_i;
        unique case (alu_ctrl)
            AluAnd: alu_res = data1_i & data2_i;
            AluOr:  alu_res = data1_i | data2_i;
            AluAdd: alu_res = data1_i + data2_i;
            AluSub: alu_res = data1_i - data2_i;
            AluSlt: alu_res = ($signed(data1_i) < $signed(data2_i)) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            // Low half of a two's-complement product is sign-agnostic.
            AluMul: alu_res = data1_i * data2_i;
`endif
            default: alu_res = data1_i + data2_i;
        endcase
    end

    assign target = pc_i + {imm_i[29:0], 2'b00};

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        target_d = target_q;
        if (flush_i) begin
            result_d = '0;
            zero_d   = 1'b0;
            target_d = '0;
        end else if (!stall_i) begin
            result_d = alu_res;
            zero_d   = (alu_res == 32'd0);
            target_d = target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            target_q <= '0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            target_q <= target_d;
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign target_o = target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit; expected values are hand-computed constants.
module tb_alu_exec_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [5:0]  funct_i;
    logic [1:0]  alu_op_i;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic [31:0] target_o;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    alu_exec_unit dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .funct_i  (funct_i),
        .alu_op_i (alu_op_i),
        .pc_i     (pc_i),
        .imm_i    (imm_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .target_o (target_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] r, input logic z,
                           input logic [31:0] t);
        chk({tag, ".result"}, result_o, r);
        chk({tag, ".zero"}, {31'd0, zero_o}, {31'd0, z});
        chk({tag, ".target"}, target_o, t);
    endtask

    // Apply inputs before an edge, then look 1 time unit after it.
    task automatic step(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
        alu_op_i = op;
        funct_i  = fn;
        data1_i  = a;
        data2_i  = b;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        data1_i = 32'h1234; data2_i = 32'h1; funct_i = 6'd0; alu_op_i = 2'b00;
        pc_i = 32'h0; imm_i = 32'h0;
        @(posedge clk_i); #1;
        chk_all("reset", 32'h0, 1'b0, 32'h0);

        @(negedge clk_i); rst_i = 1'b1;
        step(2'b10, 6'b100000, 32'hC, 32'hA); chk_all("add", 32'h16, 1'b0, 32'h0);
        step(2'b10, 6'b100010, 32'hC, 32'hA); chk("sub", result_o, 32'h2);
        step(2'b10, 6'b100100, 32'hC, 32'hA); chk("and", result_o, 32'h8);
        step(2'b10, 6'b100101, 32'hC, 32'hA); chk("or", result_o, 32'hE);
        step(2'b10, 6'b101010, 32'hC, 32'hA); chk_all("slt_false", 32'h0, 1'b1, 32'h0);
        step(2'b00, 6'b000000, 32'hFFFFFFFF, 32'h1); chk_all("wrap", 32'h0, 1'b1, 32'h0);
        step(2'b10, 6'b101010, 32'hFFFFFFFE, 32'h1); chk_all("slt_neg", 32'h1, 1'b0, 32'h0);

        pc_i = 32'h100; imm_i = 32'hFFFFFFFE;
        step(2'b01, 6'b000000, 32'h55, 32'h55); chk_all("beq_back", 32'h0, 1'b1, 32'hF8);
        imm_i = 32'h3;
        step(2'b01, 6'b000000, 32'h55, 32'h54); chk_all("beq_fwd", 32'h1, 1'b0, 32'h10C);

        step(2'b11, 6'b101010, 32'hF0, 32'h0F); chk("ori", result_o, 32'hFF);
        step(2'b10, 6'b000111, 32'h5, 32'h6); chk("funct_other", result_o, 32'hB);
        step(2'b10, 6'b011000, 32'hFFFFFFFD, 32'h7);
`ifdef ALU_MUL_EN
        chk("mul", result_o, 32'hFFFFFFEB);
`else
        chk("mul_as_add", result_o, 32'h4);
`endif

        step(2'b10, 6'b100000, 32'h20, 32'h3); chk_all("pre_stall", 32'h23, 1'b0, 32'h10C);
        stall_i = 1'b1; pc_i = 32'h200;
        step(2'b10, 6'b100010, 32'h7, 32'h7); chk_all("stall1", 32'h23, 1'b0, 32'h10C);
        step(2'b00, 6'b000000, 32'h9, 32'h9); chk_all("stall2", 32'h23, 1'b0, 32'h10C);
        flush_i = 1'b1;
        step(2'b00, 6'b000000, 32'h9, 32'h9); chk_all("flush_stall", 32'h0, 1'b0, 32'h0);
        stall_i = 1'b0; flush_i = 1'b0;
        step(2'b00, 6'b000000, 32'h9, 32'h9); chk_all("resume", 32'h12, 1'b0, 32'h20C);

        // Asynchronous reset between edges.
        @(negedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 1'b0, 32'h0);
        @(posedge clk_i); #1;
        chk_all("rst_hold", 32'h0, 1'b0, 32'h0);
        @(negedge clk_i); rst_i = 1'b1;
        step(2'b10, 6'b100101, 32'h100, 32'h1); chk_all("post_rst", 32'h101, 1'b0, 32'h20C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic block of the five-stage pipelined CPU. Decodes the 2-bit ALU operation class and R-type function field into an internal ALU control code. Computes the 32-bit ALU result and zero flag, plus the branch target (PC+4 plus word-scaled immediate). All three results are registered into one output stage feeding EX/MEM and branch/flush logic.

## Interface
- No parameters; data width fixed at 32 bits.
- clk_i  input  1  clock, rising-edge.
- rst_i  input  1  reset, asynchronous, active-low.
- stall_i  input  1  hold output register contents.
- flush_i  input  1  clear output register contents.
- data1_i  input  32  operand A (forwarded rs value).
- data2_i  input  32  operand B (forwarded rt or sign-extended immediate).
- funct_i  input  6  instruction funct field (immediate bits [5:0]).
- alu_op_i  input  2  operation class from main control.
- pc_i  input  32  PC+4 of the instruction.
- imm_i  input  32  sign-extended immediate.
- result_o  output  32  registered ALU result.
- zero_o  output  1  registered flag, 1 when ALU result == 0.
- target_o  output  32  registered branch target.

## Operation
- Control decode (combinational, internal 3-bit code):
  - alu_op_i 00 → ADD (lw/sw/addi).
  - alu_op_i 01 → SUB (beq).
  - alu_op_i 11 → OR (ori).
  - alu_op_i 10 → decode funct_i: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 011000 MUL.
  - Any other funct → ADD.
- Internal codes: AND 000, OR 001, ADD 010, MUL 011, SUB 110, SLT 111.
- ALU:
  - ADD/SUB wrap modulo 2^32; no overflow flag.
  - AND/OR are bitwise.
  - SLT is a signed compare, result 32'd1 or 32'd0.
  - MUL gives the low 32 bits of the signed product.
- Zero is computed from the 32-bit ALU result.
- Adder: target = pc_i + {imm_i[29:0], 2'b00}, wrapping modulo 2^32. Computed every cycle, independent of the ALU operation.

## Timing
- Latency is 1 cycle: inputs sampled at a rising edge appear on the outputs after that edge.
- Reset: rst_i low asynchronously forces result_o=0, zero_o=0, target_o=0. They stay there while rst_i is low. The first capture happens on the first rising edge after rst_i goes high.
- flush_i high at an edge: all outputs load 0, zero_o included.
- stall_i high at an edge (flush_i low): outputs hold their previous values.
- flush_i and stall_i both high: flush wins.
- Inputs may change freely between edges; only values at the edge matter.
- No handshake, no internal state beyond the output register.

## Configuration
- Macro ALU_MUL_EN.
- Defined: funct 011000 under alu_op_i 10 selects MUL as above; the multiplier is synthesized.
- Undefined:
  - No multiplier is synthesized.
  - funct 011000 falls into the "other funct" case and executes ADD.
  - Code 011 is never generated.

## Test plan
- Reset: hold rst_i low mid-operation with nonzero outputs → all outputs 0 immediately, without waiting for a clock edge. Release → next edge captures inputs.
- R-type ops, alu_op_i=10, A=0x0000000C, B=0x0000000A:
  - funct 100000 → result 0x16.
  - funct 100010 → 0x2.
  - funct 100100 → 0x8.
  - funct 100101 → 0xE.
  - funct 101010 → 0 (zero_o=1).
- Wrap and SLT, signed:
  - alu_op_i=00, A=0xFFFFFFFF, B=1 → result 0, zero_o=1.
  - funct 101010, A=0xFFFFFFFE (-2), B=1 → result 1.
- Branch, alu_op_i=01, A=B=0x55 → zero_o=1 and result 0. Branch target:
  - pc_i=0x100, imm_i=0xFFFFFFFE → target_o=0xF8.
  - imm_i=3 → 0x10C.
- MUL, A=0xFFFFFFFD (-3), B=7:
  - With ALU_MUL_EN → 0xFFFFFFEB.
  - Without it → 0x4 (ADD).
- Pipeline control:
  - stall_i=1 for 2 edges with changing inputs → outputs unchanged.
  - flush_i=1 with stall_i=1 → outputs 0 next edge.
